// File: rtl/bist_pkg.sv
// Shared types and constants for the full-adder BIST sequencer.
// FSM state enum, pattern counter sizing and default MISR constants.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    COMPARE,
    DONE
  } state_t;

  localparam int PAT_W   = 3;
  localparam int NUM_PAT = 8;

  localparam logic [7:0] DEF_POLY   = 8'h1D;
  localparam logic [7:0] DEF_SEED   = 8'h00;
  localparam logic [7:0] DEF_GOLDEN = 8'hC5;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting 2-bit CUT responses.
// Ports: clk, rst_n, load (seed), en (shift+xor din), seed, din, sig.
module bist_misr
  import bist_pkg::*;
#(
  parameter int              SIG_W = 8,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] seed,
  input  logic [1:0]       din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] fb;
  logic [SIG_W-1:0] dext;

  assign fb   = sig[SIG_W-1] ? POLY : '0;
  assign dext = {{(SIG_W-2){1'b0}}, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ fb ^ dext;
    end
  end

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: walks 8 full-adder patterns, compacts into a MISR, checks golden.
// Ports: clk, rst_n, start, cut_resp -> cut_a/b/cin, busy, done, pass, signature.
// Optional BIST_DIAG_EN adds fail_seen / fail_idx from a reference adder.
module bist_controller
  import bist_pkg::*;
#(
  parameter int               SIG_W      = 8,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED       = SIG_W'(DEF_SEED),
  parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(DEF_GOLDEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cut_resp,
  output logic             cut_a,
  output logic             cut_b,
  output logic             cut_cin,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
`ifdef BIST_DIAG_EN
  ,
  output logic             fail_seen,
  output logic [PAT_W-1:0] fail_idx
`endif
);

  state_t           state;
  logic [PAT_W-1:0] cnt;
  logic             last;
  logic             diag_ok;

  assign last = (cnt == PAT_W'(NUM_PAT - 1));

  bist_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == INIT),
    .en    (state == RUN),
    .seed  (SEED),
    .din   (cut_resp),
    .sig   (signature)
  );

`ifdef BIST_DIAG_EN
  logic [1:0] exp_resp;
  logic       mism;

  // Reference full adder on the pattern currently driven.
  assign exp_resp = {cut_a ^ cut_b ^ cut_cin,
                     (cut_a & cut_b) | (cut_a & cut_cin) | (cut_b & cut_cin)};
  assign mism     = (state == RUN) && (cut_resp != exp_resp);
  assign diag_ok  = ~fail_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen <= 1'b0;
      fail_idx  <= '0;
    end else if (state == INIT) begin
      fail_seen <= 1'b0;
      fail_idx  <= '0;
    end else if (mism && !fail_seen) begin
      fail_seen <= 1'b1;
      fail_idx  <= cnt;
    end
  end
`else
  assign diag_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cut_a   <= 1'b0;
      cut_b   <= 1'b0;
      cut_cin <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= INIT;
            busy  <= 1'b1;
          end
        end
        INIT: begin
          cnt                   <= '0;
          {cut_a, cut_b, cut_cin} <= '0;
          state                 <= RUN;
        end
        RUN: begin
          // Counter wraps to 0 on the final capture.
          cnt <= cnt + PAT_W'(1);
          if (last) begin
            {cut_a, cut_b, cut_cin} <= '0;
            state                 <= COMPARE;
          end else begin
            {cut_a, cut_b, cut_cin} <= cnt + PAT_W'(1);
          end
        end
        COMPARE: begin
          pass  <= (signature == GOLDEN_SIG) && diag_ok;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (start) begin
            state <= INIT;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller against a behavioural CUT and MISR model.
// Directed and randomized runs; summary line at the end.
module tb_bist_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] cut_resp;
  logic       cut_a;
  logic       cut_b;
  logic       cut_cin;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;
`ifdef BIST_DIAG_EN
  logic       fail_seen;
  logic [2:0] fail_idx;
`endif

  logic [2:0] pat;
  logic [1:0] tab [8];
  int         n_cmp;
  int         n_bad;

  assign pat = {cut_a, cut_b, cut_cin};

  always_comb cut_resp = tab[pat];

  bist_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cut_resp  (cut_resp),
    .cut_a     (cut_a),
    .cut_b     (cut_b),
    .cut_cin   (cut_cin),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
`ifdef BIST_DIAG_EN
    ,
    .fail_seen (fail_seen),
    .fail_idx  (fail_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] fa(input int p);
    int n;
    n = ((p >> 2) & 1) + ((p >> 1) & 1) + (p & 1);
    return {1'(n % 2), 1'(n / 2)};
  endfunction

  function automatic logic [7:0] model_sig();
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      s = s * 2;
      if (s >= 256) s = (s - 256) ^ 'h1D;
      s = s ^ int'(tab[i]);
    end
    return 8'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_good();
    for (int i = 0; i < 8; i++) tab[i] = fa(i);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pat"}, pat, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_sig"}, signature, 0);
`ifdef BIST_DIAG_EN
    chk({tag, "_fseen"}, fail_seen, 0);
    chk({tag, "_fidx"}, fail_idx, 0);
`endif
  endtask

  // One full run from the start-sampling edge to DONE.
  task automatic run_test(input bit jitter);
    logic [7:0] es;
    bit         ep;
    bit         fs;
    int         fidx;
    es   = model_sig();
    fs   = 0;
    fidx = 0;
    for (int i = 0; i < 8; i++)
      if (!fs && tab[i] != fa(i)) begin
        fs   = 1;
        fidx = i;
      end
    ep = (es == 8'hC5);
`ifdef BIST_DIAG_EN
    ep = ep && !fs;
`endif
    start = 1'b1;
    tick();
    start = jitter ? 1'($urandom) : 1'b0;
    chk("init_busy", busy, 1);
    chk("init_done", done, 0);
    chk("init_pat", pat, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("run_pat", pat, i);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      if (jitter) start = 1'($urandom);
      tick();
    end
    chk("cmp_pat", pat, 0);
    chk("cmp_busy", busy, 1);
    chk("cmp_done", done, 0);
    tick();
    start = 1'b0;
    chk("done_done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_pat", pat, 0);
    chk("done_sig", signature, es);
    chk("done_pass", pass, ep);
`ifdef BIST_DIAG_EN
    chk("done_fseen", fail_seen, fs);
    if (fs) chk("done_fidx", fail_idx, fidx);
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    set_good();
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_zero("idle");

    // Fault-free golden run, plus fixed golden value.
    run_test(0);
    chk("golden_const", signature, 8'hC5);
    chk("golden_pass", pass, 1);

    // Restart from DONE reproduces the same result.
    run_test(1);
    chk("rerun_sig", signature, 8'hC5);

    // Sum stuck at 1.
    for (int i = 0; i < 8; i++) tab[i] = {1'b1, fa(i) & 2'b01};
    run_test(0);
    chk("stuck_pass", pass, 0);

    // Reset while pattern 4 is driven.
    set_good();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (4) tick();
    chk("pre_rst_pat", pat, 4);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midrun_rst");
    #2 rst_n = 1'b1;
    tick();
    chk_zero("post_rst");
    run_test(0);

    // Level-high start: DONE every 11 edges (10-cycle latency + DONE sample).
    start = 1'b1;
    for (int c = 0; c < 33; c++) begin
      tick();
      chk("held_done", done, (c % 11) == 10);
      if ((c % 11) == 10) chk("held_sig", signature, 8'hC5);
    end
    start = 1'b0;
    tick();
    chk("held_stop", done, 1);

    // Randomized CUT fault tables.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++)
        tab[i] = ($urandom_range(3) == 0) ? 2'($urandom) : fa(i);
      run_test(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
